response_collector: RTL and testbench
=====================================

# response_collector

Gathers the outputs of the ripple adder under test (sum[N-1:0], cout) and returns them to the tester through one serial pin. It is the response side of the input fan-out that drives a, b and cin from two pins.
- On each accepted capture, the block latches the N+1-bit response word and shifts it out LSB-first, one bit per clock.
- In parallel, it XOR-folds every captured word into a signature register that the tester can read at the end of a pattern set.

## Interface
Parameters:
- N, 16, adder width; legal range N >= 1; response word width is N+1

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- sum  input  N  adder sum outputs; sampled only on an accepted capture edge
- cout  input  1  adder carry-out; sampled with sum
- capture  input  1  request to latch {cout,sum} and start shifting
- sig_clr  input  1  clears the signature register
- pin_s  output  1  serial response bit, registered
- pin_valid  output  1  pin_s carries a response bit this cycle
- pin_last  output  1  high with the final bit (cout) of a word
- busy  output  1  a word is being shifted out
- sig  output  N+1  bitwise-XOR signature of all words captured since reset or the last clear

## Operation
- States:
  - IDLE: pin_valid=0, busy=0.
  - SHIFT: pin_valid=1, busy=1.
- Internal registers:
  - shreg[N:0]
  - bit counter cnt, width $clog2(N+1), range 0..N
- Capture acceptance:
  - A capture is accepted when capture=1 and either the state is IDLE, or the state is SHIFT with cnt==N (last bit on the pin).
  - An accepted capture loads shreg <= {cout,sum} and cnt <= 0, and the state becomes SHIFT.
  - capture=1 in SHIFT with cnt<N is ignored: no effect on the stream or on sig.
- Serial output:
  - In SHIFT, pin_s shows shreg bit cnt, i.e. word bit k in the k-th SHIFT cycle.
  - Order is sum[0] … sum[N-1], then cout.
  - pin_last = (state==SHIFT && cnt==N).
- Leaving SHIFT:
  - When cnt==N and no capture is accepted, the next state is IDLE, and pin_s and pin_valid go to 0.
  - When cnt==N and a capture is accepted, the next word starts with no gap.
- Signature update, each cycle:
  - sig_clr=1 with an accepted capture: sig <= {cout,sum}.
  - sig_clr=1 alone: sig <= 0.
  - Accepted capture alone: sig <= sig ^ {cout,sum}.
  - Otherwise sig holds.
- Changes on sum/cout after the capture edge never affect the word in flight.

## Timing
- Reset:
  - rst=1 at an edge forces state IDLE, cnt=0, shreg=0, sig=0.
  - It also forces pin_s=0, pin_valid=0, pin_last=0, busy=0.
  - rst has priority over capture and sig_clr.
  - Reset mid-shift aborts the word: no pin_last, and the remaining bits are lost.
- Latency, with capture accepted at edge t:
  - Cycle t+1: pin_valid=1, busy=1, pin_s=sum[0].
  - Cycle t+1+k: bit k.
  - Cycle t+1+N: cout with pin_last=1.
  - Cycle t+2+N: pin_valid=0 unless a capture was accepted at edge t+1+N.
- Throughput: one word per N+1 cycles maximum, gapless when capture is asserted during the pin_last cycle.
- sig updates at the same edge that accepts the capture and is visible at t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- N=16, reset then capture with sum=0xA5C3, cout=1:
  - pin_s over 17 cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,1.
  - pin_last only on the 17th bit.
  - busy=0 and pin_valid=0 on the 18th cycle.
  - sig=0x1A5C3.
- Back-to-back words:
  - Capture 0x0001/cout=0, then assert capture with 0x8000/cout=1 exactly in the pin_last cycle.
  - Expect 34 contiguous valid bits: bit0 of word 1 =1, bit 15 of word 2 =1, final bit =1.
  - pin_valid has no gap.
- Ignored capture:
  - Hold capture=1 for 5 cycles after the first acceptance while sum changes to 0xFFFF.
  - The stream and sig reflect only the first word.
  - The next acceptance occurs in the pin_last cycle.
- Signature fold:
  - Capture 0x00FF/cout=0, then 0x0F0F/cout=1: sig=0x10FF0.
  - sig_clr alone: sig=0.
  - sig_clr together with a capture of 0x1234/cout=0: sig=0x01234.
- Reset mid-operation:
  - Assert rst during the 6th shift bit.
  - Next cycle all outputs are 0 and state is IDLE; pin_last never appears.
  - A fresh capture afterwards streams correctly.
- N=1 corner:
  - Capture sum=1, cout=0.
  - Expect 2 bits (1,0), with pin_last on the second.

Source files
------------

// File: rtl/response_collector.sv
// response_collector: latches the adder response {cout,sum} on an accepted
// capture, streams it LSB-first on pin_s, and XOR-folds each captured word
// into a readable signature register.
module response_collector #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sum,
  input  logic         cout,
  input  logic         capture,
  input  logic         sig_clr,
  output logic         pin_s,
  output logic         pin_valid,
  output logic         pin_last,
  output logic         busy,
  output logic [N:0]   sig
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N:0]    shreg, shreg_n;
  logic [N:0]    sig_n;
  logic [N:0]    word;
  logic          accept;
  logic          pin_s_n, pin_valid_n, pin_last_n, busy_n;

  assign word = {cout, sum};

  // Capture acceptance, next state, counter, shift register and signature.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    sig_n   = sig;
    accept  = 1'b0;

    // A new word may start while idle or while the previous word's last
    // bit is on the pin; anything else is dropped.
    if (capture && (state == IDLE || cnt == CNT_LAST)) begin
      accept = 1'b1;
    end

    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      shreg_n = word;
    end else if (state == SHIFT) begin
      if (cnt == CNT_LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end

    if (sig_clr && accept) begin
      sig_n = word;
    end else if (sig_clr) begin
      sig_n = '0;
    end else if (accept) begin
      sig_n = sig ^ word;
    end
  end

  // Pin outputs are computed from the upcoming state so they can be held in
  // flops and still line up with the cycle in which that state is current.
  always_comb begin
    pin_s_n     = 1'b0;
    pin_valid_n = 1'b0;
    pin_last_n  = 1'b0;
    busy_n      = 1'b0;
    if (state_n == SHIFT) begin
      pin_s_n     = shreg_n[cnt_n];
      pin_valid_n = 1'b1;
      busy_n      = 1'b1;
      pin_last_n  = (cnt_n == CNT_LAST);
    end
  end

  // State, datapath and registered outputs; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      sig       <= '0;
      pin_s     <= 1'b0;
      pin_valid <= 1'b0;
      pin_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      sig       <= sig_n;
      pin_s     <= pin_s_n;
      pin_valid <= pin_valid_n;
      pin_last  <= pin_last_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_response_collector.sv
// Directed bench for response_collector: N=16 instance for the main cases
// and an N=1 instance for the single-bit-word corner.
module tb_response_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sum = '0;
  logic        cout = 1'b0;
  logic        capture = 1'b0;
  logic        sig_clr = 1'b0;
  logic        pin_s, pin_valid, pin_last, busy;
  logic [16:0] sig;

  logic [0:0]  sum_1 = '0;
  logic        cout_1 = 1'b0;
  logic        capture_1 = 1'b0;
  logic        sig_clr_1 = 1'b0;
  logic        pin_s_1, pin_valid_1, pin_last_1, busy_1;
  logic [1:0]  sig_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  response_collector #(.N(16)) dut (
    .clk(clk), .rst(rst), .sum(sum), .cout(cout), .capture(capture),
    .sig_clr(sig_clr), .pin_s(pin_s), .pin_valid(pin_valid),
    .pin_last(pin_last), .busy(busy), .sig(sig)
  );

  response_collector #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .sum(sum_1), .cout(cout_1), .capture(capture_1),
    .sig_clr(sig_clr_1), .pin_s(pin_s_1), .pin_valid(pin_valid_1),
    .pin_last(pin_last_1), .busy(busy_1), .sig(sig_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input int k, input logic [16:0] w);
    chk($sformatf("%s_valid%0d", tag, k), {31'd0, pin_valid}, 32'd1);
    chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
    chk($sformatf("%s_bit%0d", tag, k), {31'd0, pin_s}, {31'd0, w[k]});
    chk($sformatf("%s_last%0d", tag, k), {31'd0, pin_last}, (k == 16) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, pin_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pin"}, {31'd0, pin_s}, 32'd0);
    chk({tag, "_last"}, {31'd0, pin_last}, 32'd0);
  endtask

  // Capture one word while idle, scramble the inputs, stream it out fully.
  task automatic send16(input string tag, input logic [16:0] w);
    sum = w[15:0];
    cout = w[16];
    capture = 1'b1;
    tick();
    capture = 1'b0;
    sum = ~w[15:0];
    cout = ~w[16];
    for (int k = 0; k <= 16; k++) begin
      chk_bit(tag, k, w);
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  initial begin
    logic [16:0] w1, w2, w3;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_sig", {15'd0, sig}, 32'd0);
    chk("reset1_valid", {31'd0, pin_valid_1}, 32'd0);
    chk("reset1_sig", {30'd0, sig_1}, 32'd0);

    // Basic word 0xA5C3 / cout=1 (bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,1)
    send16("basic", 17'h1A5C3);
    chk("basic_sig", {15'd0, sig}, 32'h1A5C3);

    // Back-to-back: second capture in the pin_last cycle, no gap
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    chk("b2b_clr", {15'd0, sig}, 32'd0);
    w1 = 17'h00001;
    w2 = 17'h18000;
    sum = w1[15:0];
    cout = w1[16];
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      chk_bit("b2b_w1", k, w1);
      if (k == 16) begin
        sum = w2[15:0];
        cout = w2[16];
        capture = 1'b1;
      end
      tick();
      capture = 1'b0;
    end
    for (int k = 0; k <= 16; k++) begin
      chk_bit("b2b_w2", k, w2);
      tick();
    end
    chk_idle("b2b_end");
    chk("b2b_sig", {15'd0, sig}, 32'h18001);

    // Ignored captures while shifting; next acceptance in pin_last cycle
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    w1 = 17'h05A5A;
    w2 = 17'h1FFFF;
    sum = w1[15:0];
    cout = w1[16];
    capture = 1'b1;
    tick();
    sum = 16'hFFFF;
    cout = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      chk_bit("ign_w1", k, w1);
      if (k == 5) chk("ign_sig_mid", {15'd0, sig}, 32'h05A5A);
      capture = (k < 5 || k == 16) ? 1'b1 : 1'b0;
      tick();
    end
    capture = 1'b0;
    chk("ign_sig_acc", {15'd0, sig}, 32'h1A5A5);
    for (int k = 0; k <= 16; k++) begin
      chk_bit("ign_w2", k, w2);
      tick();
    end
    chk_idle("ign_end");

    // Signature fold and clear variants
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    send16("fold_a", 17'h000FF);
    send16("fold_b", 17'h10F0F);
    chk("fold_sig", {15'd0, sig}, 32'h10FF0);
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    chk("clr_alone", {15'd0, sig}, 32'd0);
    chk_idle("clr_alone");
    w3 = 17'h01234;
    sum = w3[15:0];
    cout = w3[16];
    sig_clr = 1'b1;
    capture = 1'b1;
    tick();
    sig_clr = 1'b0;
    capture = 1'b0;
    chk("clr_cap_sig", {15'd0, sig}, 32'h01234);
    for (int k = 0; k <= 16; k++) begin
      chk_bit("clr_cap", k, w3);
      tick();
    end
    chk_idle("clr_cap_end");

    // Reset during the 6th shift bit aborts the word
    w1 = 17'h1FFFF;
    sum = w1[15:0];
    cout = w1[16];
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk_bit("mid", k, w1);
      if (k == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_sig", {15'd0, sig}, 32'd0);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("mid_after_last%0d", k), {30'd0, pin_last, pin_valid}, 32'd0);
      tick();
    end
    send16("mid_fresh", 17'h11357);
    chk("mid_fresh_sig", {15'd0, sig}, 32'h11357);

    // N=1 corner: word {cout=0,sum=1} -> bits 1,0
    sum_1 = 1'b1;
    cout_1 = 1'b0;
    capture_1 = 1'b1;
    tick();
    capture_1 = 1'b0;
    sum_1 = 1'b0;
    chk("n1_b0", {29'd0, pin_valid_1, pin_s_1, pin_last_1}, 32'b110);
    chk("n1_sig", {30'd0, sig_1}, 32'b01);
    tick();
    chk("n1_b1", {29'd0, pin_valid_1, pin_s_1, pin_last_1}, 32'b101);
    tick();
    chk("n1_end", {29'd0, pin_valid_1, busy_1, pin_last_1}, 32'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
